// File: rtl/mem_burst_if.sv
// Burst memory bus: request channel, write-beat channel and read-beat channel.
// The master is the requester and the slave is the memory block.
interface mem_burst_if #(
  parameter int DATA_W = 256,
  parameter int ELEM_W = 16,
  parameter int DEPTH  = 8
) ();
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NELEM  = DATA_W / ELEM_W;

  logic              memReqValid;
  logic              memReqReady;
  logic              memReqRW;
  logic [ADDR_W-1:0] memReqAddr;
  logic [ADDR_W-1:0] memReqLen;

  logic              memWrValid;
  logic              memWrReady;
  logic [DATA_W-1:0] memWrData;
  logic [NELEM-1:0]  memWrMask;

  logic              memRdValid;
  logic              memRdReady;
  logic [DATA_W-1:0] memRdData;
  logic              memRdLast;

  logic              memBusy;

  modport master (
    output memReqValid, memReqRW, memReqAddr, memReqLen,
    output memWrValid, memWrData, memWrMask, memRdReady,
    input  memReqReady, memWrReady, memRdValid, memRdData, memRdLast, memBusy
  );

  modport slave (
    input  memReqValid, memReqRW, memReqAddr, memReqLen,
    input  memWrValid, memWrData, memWrMask, memRdReady,
    output memReqReady, memWrReady, memRdValid, memRdData, memRdLast, memBusy
  );
endinterface

// File: rtl/mem_burst.sv
// Row-wide burst memory: one request starts a read or write burst of memReqLen+1
// consecutive rows (wrapping), with element-masked writes and a registered read stage.
module mem_burst #(
  parameter int DATA_W = 256,
  parameter int ELEM_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic         clk,
  input  logic         nReset,
  mem_burst_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NELEM  = DATA_W / ELEM_W;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] lenReg;
  logic [ADDR_W-1:0] beatCnt;
  logic              issueDone;
  logic              rdValid;
  logic              rdLast;
  logic [DATA_W-1:0] rdData;
  logic [DATA_W-1:0] mem [DEPTH];

  logic reqFire;
  logic wrFire;
  logic rdFire;
  logic rdLoad;

  assign reqFire = bus.memReqValid && (state == IDLE);
  assign wrFire  = bus.memWrValid && (state == WRITE);
  assign rdFire  = rdValid && bus.memRdReady;
  // Refill the output register when it is empty or its beat leaves this cycle.
  assign rdLoad  = (state == READ) && !issueDone && (!rdValid || bus.memRdReady);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state     <= IDLE;
      addr      <= '0;
      lenReg    <= '0;
      beatCnt   <= '0;
      issueDone <= 1'b0;
      rdValid   <= 1'b0;
      rdLast    <= 1'b0;
      rdData    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqFire) begin
            addr      <= bus.memReqAddr;
            lenReg    <= bus.memReqLen;
            beatCnt   <= '0;
            issueDone <= 1'b0;
            state     <= bus.memReqRW ? READ : WRITE;
          end
        end
        READ: begin
          if (rdLoad) begin
            rdData    <= mem[addr];
            rdValid   <= 1'b1;
            rdLast    <= (beatCnt == lenReg);
            issueDone <= (beatCnt == lenReg);
            addr      <= addr + ADDR_W'(1);
            beatCnt   <= beatCnt + ADDR_W'(1);
          end else if (rdFire) begin
            rdValid <= 1'b0;
            rdLast  <= 1'b0;
          end
          if (rdFire && rdLast) state <= IDLE;
        end
        WRITE: begin
          if (wrFire) begin
            addr    <= addr + ADDR_W'(1);
            beatCnt <= beatCnt + ADDR_W'(1);
            if (beatCnt == lenReg) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array is deliberately left out of reset; reset only blocks the
  // write in the cycle it is asserted so an aborted burst cannot touch memory.
  always_ff @(posedge clk) begin
    if (nReset && wrFire) begin
      for (int i = 0; i < NELEM; i++) begin
        if (bus.memWrMask[i]) mem[addr][i*ELEM_W +: ELEM_W] <= bus.memWrData[i*ELEM_W +: ELEM_W];
      end
    end
  end

  assign bus.memReqReady = (state == IDLE);
  assign bus.memWrReady  = (state == WRITE);
  assign bus.memBusy     = (state != IDLE);
  assign bus.memRdValid  = rdValid;
  assign bus.memRdLast   = rdLast;
  assign bus.memRdData   = rdData;
endmodule

// File: tb/tb_mem_burst.sv
// Self-checking bench for mem_burst: directed bursts plus random traffic, checked
// against a row-array model updated only by accepted write beats.
module tb_mem_burst;
  localparam int DATA_W = 256;
  localparam int ELEM_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int NELEM  = DATA_W / ELEM_W;

  logic clk    = 1'b0;
  logic nReset = 1'b0;

  mem_burst_if #(.DATA_W(DATA_W), .ELEM_W(ELEM_W), .DEPTH(DEPTH)) bus ();

  mem_burst #(.DATA_W(DATA_W), .ELEM_W(ELEM_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] refMem [DEPTH];
  logic [DATA_W-1:0] wrRows [$];
  logic [NELEM-1:0]  wrMasks [$];
  int checkCount = 0;
  int passCount  = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] fill(input logic [ELEM_W-1:0] e);
    return {NELEM{e}};
  endfunction

  function automatic logic [DATA_W-1:0] randRow();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void modelWrite(input int row, input logic [DATA_W-1:0] d, input logic [NELEM-1:0] m);
    for (int i = 0; i < NELEM; i++)
      if (m[i]) refMem[row][i*ELEM_W +: ELEM_W] = d[i*ELEM_W +: ELEM_W];
  endfunction

  task automatic idleInputs();
    bus.memReqValid = 1'b0;
    bus.memReqRW    = 1'b0;
    bus.memReqAddr  = '0;
    bus.memReqLen   = '0;
    bus.memWrValid  = 1'b0;
    bus.memWrData   = '0;
    bus.memWrMask   = '0;
    bus.memRdReady  = 1'b0;
  endtask

  task automatic sendReq(input logic rw, input int addr, input int len);
    int c = 0;
    bus.memReqValid = 1'b1;
    bus.memReqRW    = rw;
    bus.memReqAddr  = ADDR_W'(addr);
    bus.memReqLen   = ADDR_W'(len);
    while (bus.memReqReady !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    check("reqAccept", DATA_W'(bus.memReqReady), DATA_W'(1));
    tick();
    bus.memReqValid = 1'b0;
  endtask

  // Writes wrRows/wrMasks as one burst; the model follows each accepted beat.
  task automatic writeBurst(input int addr, input int len);
    sendReq(1'b0, addr, len);
    for (int k = 0; k <= len; k++) begin
      bus.memWrValid = 1'b1;
      bus.memWrData  = wrRows[k];
      bus.memWrMask  = wrMasks[k];
      check("wrReady", DATA_W'(bus.memWrReady), DATA_W'(1));
      tick();
      modelWrite((addr + k) % DEPTH, wrRows[k], wrMasks[k]);
    end
    bus.memWrValid = 1'b0;
    check("wrDoneIdle", DATA_W'(bus.memBusy), DATA_W'(0));
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic readBurst(input int addr, input int len, input int mode);
    int k = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    sendReq(1'b1, addr, len);
    check("rdLatency0", DATA_W'(bus.memRdValid), DATA_W'(0));
    tick();
    while (k <= len && cyc < 200) begin
      bus.memRdReady = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      bus.memWrValid = 1'($urandom_range(0, 1));
      bus.memWrData  = fill(16'hDEAD);
      bus.memWrMask  = '1;
      check("rdWrReady", DATA_W'(bus.memWrReady), DATA_W'(0));
      if (cyc == 0) check("rdLatency1", DATA_W'(bus.memRdValid), DATA_W'(1));
      if (stalled) check("stallValid", DATA_W'(bus.memRdValid), DATA_W'(1));
      if (bus.memRdValid === 1'b1) begin
        check("rdData", bus.memRdData, refMem[(addr + k) % DEPTH]);
        check("rdLast", DATA_W'(bus.memRdLast), DATA_W'(k == len));
        if (bus.memRdReady) begin
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
      end else begin
        stalled = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.memRdReady = 1'b0;
    bus.memWrValid = 1'b0;
    check("rdBeats", DATA_W'(k), DATA_W'(len + 1));
    if (mode == 0) check("rdNoBubble", DATA_W'(cyc), DATA_W'(len + 1));
    check("rdDoneValid", DATA_W'(bus.memRdValid), DATA_W'(0));
    check("rdDoneBusy", DATA_W'(bus.memBusy), DATA_W'(0));
  endtask

  initial begin
    idleInputs();
    nReset = 1'b0;
    tick();
    tick();
    check("rstReqReady", DATA_W'(bus.memReqReady), DATA_W'(1));
    check("rstWrReady", DATA_W'(bus.memWrReady), DATA_W'(0));
    check("rstRdValid", DATA_W'(bus.memRdValid), DATA_W'(0));
    check("rstRdLast", DATA_W'(bus.memRdLast), DATA_W'(0));
    check("rstBusy", DATA_W'(bus.memBusy), DATA_W'(0));
    check("rstRdData", bus.memRdData, '0);
    nReset = 1'b1;

    // Full-depth write so every model row is defined.
    wrRows.delete(); wrMasks.delete();
    for (int i = 0; i < DEPTH; i++) begin
      wrRows.push_back(randRow());
      wrMasks.push_back('1);
    end
    writeBurst($urandom_range(0, DEPTH - 1), DEPTH - 1);

    // Basic write then read back-to-back.
    wrRows.delete(); wrMasks.delete();
    wrRows.push_back(fill(16'hAAAA)); wrRows.push_back(fill(16'hBBBB)); wrRows.push_back(fill(16'hCCCC));
    for (int i = 0; i < 3; i++) wrMasks.push_back('1);
    writeBurst(2, 2);
    readBurst(2, 2, 0);

    // Address wrap 6, 7, 0, 1.
    wrRows.delete(); wrMasks.delete();
    for (int i = 0; i < 4; i++) begin
      wrRows.push_back(randRow());
      wrMasks.push_back('1);
    end
    writeBurst(6, 3);
    readBurst(6, 3, 0);

    // Element mask: only element 0 of row 3 is cleared.
    wrRows.delete(); wrMasks.delete();
    wrRows.push_back(fill(16'hFFFF)); wrMasks.push_back('1);
    writeBurst(3, 0);
    wrRows.delete(); wrMasks.delete();
    wrRows.push_back('0); wrMasks.push_back(16'h0001);
    writeBurst(3, 0);
    readBurst(3, 0, 0);
    check("maskElem0", DATA_W'(refMem[3][15:0]), DATA_W'(0));

    // Backpressure.
    readBurst(0, 3, 1);

    // Write beats offered while idle are ignored.
    bus.memWrValid = 1'b1;
    bus.memWrData  = fill(16'hDEAD);
    bus.memWrMask  = '1;
    for (int i = 0; i < 4; i++) begin
      check("idleWrReady", DATA_W'(bus.memWrReady), DATA_W'(0));
      tick();
    end
    bus.memWrValid = 1'b0;
    readBurst(0, DEPTH - 1, 0);

    // Reset after the first beat of a read.
    sendReq(1'b1, 1, 3);
    tick();
    bus.memRdReady = 1'b1;
    check("midRdBeat1", bus.memRdData, refMem[1]);
    tick();
    nReset = 1'b0;
    bus.memRdReady = 1'b0;
    tick();
    nReset = 1'b1;
    check("midRdValid", DATA_W'(bus.memRdValid), DATA_W'(0));
    check("midRdBusy", DATA_W'(bus.memBusy), DATA_W'(0));
    check("midRdReqReady", DATA_W'(bus.memReqReady), DATA_W'(1));
    readBurst(1, 3, 0);

    // Reset during the third beat of a write: two rows land, the third does not.
    sendReq(1'b0, 4, 3);
    for (int k = 0; k < 2; k++) begin
      bus.memWrValid = 1'b1;
      bus.memWrData  = randRow();
      bus.memWrMask  = '1;
      tick();
      modelWrite(4 + k, bus.memWrData, '1);
    end
    bus.memWrData = fill(16'hBAD0);
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    bus.memWrValid = 1'b0;
    check("midWrBusy", DATA_W'(bus.memBusy), DATA_W'(0));
    readBurst(4, 3, 0);

    // Random traffic.
    for (int n = 0; n < 24; n++) begin
      int a = $urandom_range(0, DEPTH - 1);
      int l = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) begin
        readBurst(a, l, 2);
      end else begin
        wrRows.delete(); wrMasks.delete();
        for (int i = 0; i <= l; i++) begin
          wrRows.push_back(randRow());
          wrMasks.push_back(NELEM'($urandom));
        end
        writeBurst(a, l);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/mem_burst.md
MEM_BURST -- requirements
Module: mem_burst

Interface
REQ-001 Parameter DATA_W, default 256: width of one memory row (one matrix row) in bits.
REQ-002 Parameter ELEM_W, default 16: width of one matrix element; DATA_W SHALL be an integer multiple of ELEM_W.
REQ-003 Parameter DEPTH, default 8: number of rows; SHALL be a power of two, at least 2.
REQ-004 Derived ADDR_W = log2(DEPTH), and NELEM = DATA_W/ELEM_W.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 nReset  in  1  synchronous active-low reset.
REQ-008 memReqValid  in  1  burst request present.
REQ-009 memReqReady  out  1  block can accept a request.
REQ-010 memReqRW  in  1  1 = read burst, 0 = write burst.
REQ-011 memReqAddr  in  ADDR_W  start row.
REQ-012 memReqLen  in  ADDR_W  beats minus one (0 = single beat, DEPTH-1 = full memory).
REQ-013 memWrValid / memWrReady  in / out  1 / 1  write-beat handshake.
REQ-014 memWrData  in  DATA_W  write row data.
REQ-015 memWrMask  in  NELEM  per-element write enable; bit i covers bits [i*ELEM_W +: ELEM_W].
REQ-016 memRdValid / memRdReady  out / in  1 / 1  read-beat handshake.
REQ-017 memRdData  out  DATA_W  registered read row.
REQ-018 memRdLast  out  1  high with the final read beat of a burst.
REQ-019 memBusy  out  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, READ and WRITE; memReqReady = 1 only in IDLE.
REQ-021 A request is accepted on a rising edge with memReqValid&memReqReady; the block latches the address and length, then enters READ (RW=1) or WRITE (RW=0).
REQ-022 READ: the row at the current address SHALL be loaded into the memRdData register when the register is empty or its beat is being accepted in the same cycle; the first memRdValid rises one cycle after request acceptance.
REQ-023 While memRdValid=1 and memRdReady=0, memRdData, memRdLast and memRdValid SHALL hold stable.
REQ-024 With memRdReady held high, the block SHALL deliver one beat per cycle (no bubbles).
REQ-025 The address SHALL increment by one per beat, modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-026 memRdLast SHALL be 1 exactly on beat memReqLen+1; on acceptance of that beat the FSM returns to IDLE, and memRdValid drops in the following cycle unless a new beat is loaded.
REQ-027 WRITE: memWrReady = 1 throughout the state; each accepted beat writes only the elements whose memWrMask bit is 1, leaving the others unchanged.
REQ-028 After the write beat numbered memReqLen+1 is accepted, the FSM returns to IDLE in the next cycle.
REQ-029 memWrReady = 0 in IDLE and READ; write beats offered then SHALL be ignored and SHALL NOT alter memory.
REQ-030 A read accepted in the cycle after the final write beat SHALL return the newly written data (no stale read).
REQ-031 A request offered while busy SHALL be held off (memReqReady=0), not dropped; the requester keeps it valid.
REQ-032 The array SHALL have no reset; contents are undefined until written.

Reset
REQ-033 With nReset=0 at a rising edge: FSM -> IDLE, memReqReady=1, memWrReady=0, memRdValid=0, memRdLast=0, memBusy=0, memRdData=0, and internal address and beat counters = 0.
REQ-034 Reset asserted mid-burst SHALL abort the burst; rows already written keep their values, and no further writes occur.

Verification (DATA_W=256, ELEM_W=16, DEPTH=8)
REQ-035 Write burst addr=2, len=2, data 0xA..A / 0xB..B / 0xC..C, mask all-ones; then read burst addr=2, len=2 with memRdReady=1 -> beats A, B, C on consecutive cycles, memRdLast only on C, first memRdValid one cycle after acceptance.
REQ-036 Wrap: write addr=6, len=3 with rows 6, 7, 0, 1; read addr=6, len=3 -> order 6, 7, 0, 1, memRdLast on row 1.
REQ-037 Mask: row 3 = all 0xFFFF; write row 3 = 0, mask=16'h0001 -> read gives element 0 = 0x0000, elements 1-15 = 0xFFFF.
REQ-038 Backpressure: read len=3 with memRdReady toggling 1,0,0,1,... -> data and memRdLast stable while stalled, all 4 beats delivered in order with none lost or duplicated.
REQ-039 Reset mid-read (after beat 1 of len=3) -> next cycle memRdValid=0, memBusy=0, memReqReady=1; a new read then returns correct data.
REQ-040 memWrValid=1 while IDLE with data 0xDEAD -> memory unchanged, memWrReady stays 0.
